// File: rtl/clock_timekeeper_if.sv
// Key inputs and time/display outputs of the time-of-day core.
// The key side (master) drives the raw keys and watches the display fields.
interface clock_timekeeper_if;
  logic       key_mode;
  logic       key_add;
  logic [4:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [7:0] hour_bcd;
  logic [7:0] minute_bcd;
  logic       pm;
  logic [1:0] mode;
  logic       edit_blink;
  logic       second_pulse;

  modport master (
    output key_mode, key_add,
    input  hour, minute, second, hour_bcd, minute_bcd, pm, mode,
           edit_blink, second_pulse
  );

  modport slave (
    input  key_mode, key_add,
    output hour, minute, second, hour_bcd, minute_bcd, pm, mode,
           edit_blink, second_pulse
  );
endinterface

// File: rtl/clock_timekeeper.sv
// Time-of-day core: cycle prescaler, HH:MM:SS counters, debounced mode/add
// keys, set-time and stop modes, blink request and BCD display fields.
module clock_timekeeper #(
  parameter int TICK_DIV        = 65536,
  parameter int DEBOUNCE_CYCLES = 1024,
  parameter bit HOUR12          = 1'b0
) (
  input logic               clock,
  input logic               reset,
  clock_timekeeper_if.slave bus
);
  localparam int PRE_W  = $clog2(TICK_DIV);
  localparam int HALF   = (TICK_DIV / 2 > 1) ? TICK_DIV / 2 : 1;
  localparam int HALF_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF - 1);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    STOP     = 2'd3
  } mode_t;

  // Increment with wrap back to zero after 'last'.
  function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] last);
    return (v == last) ? 6'd0 : v + 6'd1;
  endfunction

  // Binary 0..59 to {tens, units} BCD.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    return {4'(v / 6'd10), 4'(v % 6'd10)};
  endfunction

  // Index 0 is the mode key, index 1 the add key.
  logic [1:0]           raw;
  logic [1:0]           sync_p0;
  logic [1:0]           sync_p1;
  logic [1:0]           level;
  logic [1:0]           press;
  logic [1:0][DB_W-1:0] stab_cnt;

  assign raw = {bus.key_add, bus.key_mode};

  // Synchronise each key, then adopt a new level once it has held steady long enough.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_p0  <= '0;
      sync_p1  <= '0;
      level    <= '0;
      press    <= '0;
      stab_cnt <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      for (int k = 0; k < 2; k++) begin
        press[k] <= 1'b0;
        if (sync_p1[k] == level[k]) begin
          stab_cnt[k] <= '0;
        end else if (stab_cnt[k] == DB_LAST) begin
          stab_cnt[k] <= '0;
          level[k]    <= sync_p1[k];
          press[k]    <= sync_p1[k];
        end else begin
          stab_cnt[k] <= stab_cnt[k] + DB_W'(1);
        end
      end
    end
  end

  // A simultaneous mode press wins; the add press is dropped.
  logic press_mode;
  logic press_add;
  assign press_mode = press[0];
  assign press_add  = press[1] & ~press[0];

  mode_t mode_q;

  // Mode sequencer: RUN -> SET_HOUR -> SET_MIN -> STOP -> RUN on each mode press.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mode_q <= RUN;
    end else if (press_mode) begin
      case (mode_q)
        RUN:      mode_q <= SET_HOUR;
        SET_HOUR: mode_q <= SET_MIN;
        SET_MIN:  mode_q <= STOP;
        default:  mode_q <= RUN;
      endcase
    end
  end

  logic [PRE_W-1:0] pre_cnt;
  logic             tick;

  // A wrap in RUN still ticks even if the mode leaves RUN on the same edge.
  assign tick = (mode_q == RUN) && (pre_cnt == PRE_LAST);

  // Prescaler runs only in RUN; held at zero otherwise so RUN always restarts a full second.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pre_cnt <= '0;
    end else if ((mode_q != RUN) || tick) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PRE_W'(1);
    end
  end

  logic [4:0] hour_q;
  logic [5:0] minute_q;
  logic [5:0] second_q;
  logic       pulse_q;

  // Time counters: ticks carry through s/m/h; add presses edit fields without carry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hour_q   <= '0;
      minute_q <= '0;
      second_q <= '0;
      pulse_q  <= 1'b0;
    end else begin
      pulse_q <= tick;
      if (tick) begin
        second_q <= inc_wrap(second_q, 6'd59);
        if (second_q == 6'd59) begin
          minute_q <= inc_wrap(minute_q, 6'd59);
          if (minute_q == 6'd59) begin
            hour_q <= 5'(inc_wrap({1'b0, hour_q}, 6'd23));
          end
        end
      end else if (press_add) begin
        case (mode_q)
          SET_HOUR: hour_q <= 5'(inc_wrap({1'b0, hour_q}, 6'd23));
          SET_MIN: begin
            minute_q <= inc_wrap(minute_q, 6'd59);
            second_q <= '0;
          end
          STOP:    second_q <= '0;
          default: ;
        endcase
      end
    end
  end

  logic [HALF_W-1:0] half_cnt;
  logic              blink_phase;

  // Free-running half-second counter; flips the blink phase on every wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      half_cnt    <= '0;
      blink_phase <= 1'b0;
    end else if (half_cnt == HALF_LAST) begin
      half_cnt    <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      half_cnt <= half_cnt + HALF_W'(1);
    end
  end

  logic [4:0] disp_hour;

  // Display hour: 00..23, or 12,1..12,1..11 in 12-hour format.
  always_comb begin
    disp_hour = hour_q;
    if (HOUR12) begin
      if (hour_q == 5'd0) begin
        disp_hour = 5'd12;
      end else if (hour_q > 5'd12) begin
        disp_hour = hour_q - 5'd12;
      end
    end
  end

  assign bus.hour         = hour_q;
  assign bus.minute       = minute_q;
  assign bus.second       = second_q;
  assign bus.hour_bcd     = to_bcd({1'b0, disp_hour});
  assign bus.minute_bcd   = to_bcd(minute_q);
  assign bus.pm           = (hour_q >= 5'd12);
  assign bus.mode         = mode_q;
  assign bus.edit_blink   = blink_phase & ((mode_q == SET_HOUR) || (mode_q == SET_MIN));
  assign bus.second_pulse = pulse_q;
endmodule

// File: tb/tb_clock_timekeeper.sv
// Directed bench for clock_timekeeper: a 24-hour and a 12-hour instance
// share the same key stimulus; time expectations and expected second_pulse
// cycles are queued when stimulus is driven and checked when due.
module tb_clock_timekeeper;
  localparam int TD = 4;
  localparam int DB = 3;

  logic clk;
  logic rst_n;
  logic key_mode;
  logic key_add;
  int   cyc = 0;
  int   vecs = 0;
  int   fails = 0;

  typedef struct {
    string tag;
    int    h;
    int    m;
    int    s;
    int    md;
  } exp_t;

  exp_t sbq[$];
  int   pq[$];
  int   r0;

  clock_timekeeper_if if0 ();
  clock_timekeeper_if if1 ();

  assign if0.key_mode = key_mode;
  assign if0.key_add  = key_add;
  assign if1.key_mode = key_mode;
  assign if1.key_add  = key_add;

  clock_timekeeper #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB), .HOUR12(1'b0)) dut0 (
    .clock(clk), .reset(rst_n), .bus(if0.slave)
  );
  clock_timekeeper #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB), .HOUR12(1'b1)) dut1 (
    .clock(clk), .reset(rst_n), .bus(if1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: sim time exceeded, summary not reached");
    $fatal(1, "timeout");
  end

  function automatic int bcd(int v);
    return (v / 10) * 16 + (v % 10);
  endfunction

  function automatic int bcd12(int h);
    int d;
    d = (h % 12 == 0) ? 12 : h % 12;
    return bcd(d);
  endfunction

  task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(int t);
    while (cyc < t) cycles(1);
  endtask

  task automatic push_state(string tag, int h, int m, int s, int md);
    exp_t e;
    e.tag = tag; e.h = h; e.m = m; e.s = s; e.md = md;
    sbq.push_back(e);
  endtask

  task automatic check_state();
    exp_t e;
    e = sbq.pop_front();
    cmp($sformatf("%s.hour", e.tag),      if0.hour,       e.h);
    cmp($sformatf("%s.minute", e.tag),    if0.minute,     e.m);
    cmp($sformatf("%s.second", e.tag),    if0.second,     e.s);
    cmp($sformatf("%s.mode", e.tag),      if0.mode,       e.md);
    cmp($sformatf("%s.pm", e.tag),        if0.pm,         (e.h >= 12) ? 1 : 0);
    cmp($sformatf("%s.hour_bcd24", e.tag), if0.hour_bcd,  bcd(e.h));
    cmp($sformatf("%s.hour_bcd12", e.tag), if1.hour_bcd,  bcd12(e.h));
    cmp($sformatf("%s.minute_bcd", e.tag), if0.minute_bcd, bcd(e.m));
    cmp($sformatf("%s.second12", e.tag),  if1.second,     e.s);
  endtask

  task automatic press(logic m, logic a);
    key_mode = m;
    key_add  = a;
    cycles(8);
    key_mode = 1'b0;
    key_add  = 1'b0;
    cycles(8);
  endtask

  task automatic add_n(int n);
    repeat (n) press(1'b0, 1'b1);
  endtask

  // Blink phase model: flips every TD/2 edges counted from reset release at r0.
  task automatic check_blink(string tag, bit active);
    for (int i = 0; i < 8; i++) begin
      int ph;
      @(negedge clk);
      ph = ((cyc - r0) / (TD / 2)) % 2;
      cmp($sformatf("%s.blink24", tag), if0.edit_blink, active ? ph : 0);
      cmp($sformatf("%s.blink12", tag), if1.edit_blink, active ? ph : 0);
    end
    @(posedge clk);
    #1;
  endtask

  // Every observed second_pulse must match the next queued cycle number.
  always @(negedge clk) begin
    if (if0.second_pulse === 1'b1 || if1.second_pulse === 1'b1) begin
      cmp("pulse_expected", (pq.size() != 0) ? 1 : 0, 1);
      if (pq.size() != 0) begin
        cmp("pulse_cycle", cyc, pq.pop_front());
        cmp("pulse24", if0.second_pulse, 1);
        cmp("pulse12", if1.second_pulse, 1);
      end
    end
  end

  initial begin
    int r;
    int q;
    rst_n    = 1'b0;
    key_mode = 1'b0;
    key_add  = 1'b0;
    r0       = 0;
    cycles(3);

    push_state("reset", 0, 0, 0, 0);
    check_state();
    cmp("reset.pulse", if0.second_pulse, 0);
    cmp("reset.blink", if0.edit_blink, 0);
    cmp("reset.blink12", if1.edit_blink, 0);

    // Release reset and press mode at once: one tick lands before SET_HOUR.
    r0 = cyc;
    pq.push_back(r0 + 4);
    push_state("enter_set_hour", 0, 0, 1, 1);
    rst_n = 1'b1;
    press(1'b1, 1'b0);
    check_state();
    check_blink("set_hour", 1'b1);

    // Bounce then a stable 10-cycle hold: exactly one add, 2+3 cycles after the rise.
    push_state("bounce", 1, 0, 1, 1);
    key_add = 1'b1; cycles(1);
    key_add = 1'b0; cycles(1);
    key_add = 1'b1; cycles(1);
    key_add = 1'b0; cycles(1);
    key_add = 1'b1; cycles(5);
    cmp("bounce.before_edge", if0.hour, 0);
    cycles(1);
    cmp("bounce.after_edge", if0.hour, 1);
    cycles(4);
    key_add = 1'b0;
    cycles(8);
    check_state();

    push_state("hour12", 12, 0, 1, 1); add_n(11); check_state();
    push_state("hour13", 13, 0, 1, 1); add_n(1);  check_state();
    push_state("hour23", 23, 0, 1, 1); add_n(10); check_state();
    push_state("hour_wrap", 0, 0, 1, 1); add_n(1); check_state();
    push_state("hour23b", 23, 0, 1, 1); add_n(23); check_state();

    // Mode and add together: mode wins, hour untouched.
    push_state("simul", 23, 0, 1, 2);
    press(1'b1, 1'b1);
    check_state();

    push_state("min1", 23, 1, 0, 2);  add_n(1);  check_state();
    push_state("min59", 23, 59, 0, 2); add_n(58); check_state();
    push_state("min_wrap", 23, 0, 0, 2); add_n(1); check_state();
    push_state("min59b", 23, 59, 0, 2); add_n(59); check_state();

    push_state("stop", 23, 59, 0, 3);
    press(1'b1, 1'b0);
    check_state();
    check_blink("stop", 1'b0);

    // RUN from 23:59:00; leave RUN on the 64th wrap edge.
    r = cyc;
    for (int k = 1; k <= 64; k++) pq.push_back(r + 6 + TD * k);
    push_state("run_start", 23, 59, 2, 0);
    press(1'b1, 1'b0);
    check_state();
    check_blink("run", 1'b0);
    push_state("t58", 23, 59, 58, 0); wait_until(r + 6 + TD * 58); check_state();
    push_state("t59", 23, 59, 59, 0); wait_until(r + 6 + TD * 59); check_state();
    push_state("rollover", 0, 0, 0, 0); wait_until(r + 6 + TD * 60); check_state();
    wait_until(r + TD * 64);
    push_state("exit_on_wrap", 0, 0, 4, 1);
    press(1'b1, 1'b0);
    check_state();
    cmp("pulses_consumed_a", pq.size(), 0);

    // STOP freezes time; add clears seconds; RUN restarts a full second.
    push_state("to_set_min", 0, 0, 4, 2); press(1'b1, 1'b0); check_state();
    push_state("to_stop", 0, 0, 4, 3);    press(1'b1, 1'b0); check_state();
    push_state("frozen", 0, 0, 4, 3);
    cycles(100);
    check_state();
    push_state("stop_clear", 0, 0, 0, 3);
    add_n(1);
    check_state();
    r = cyc;
    for (int k = 1; k <= 4; k++) pq.push_back(r + 6 + TD * k);
    press(1'b1, 1'b0);
    push_state("restart", 0, 0, 4, 1);
    press(1'b1, 1'b0);
    check_state();
    cmp("pulses_consumed_b", pq.size(), 0);

    // Reset in the middle of a mode-key debounce clears everything at once.
    key_mode = 1'b1;
    cycles(3);
    rst_n = 1'b0;
    #1;
    push_state("mid_reset", 0, 0, 0, 0);
    check_state();
    cmp("mid_reset.pulse", if0.second_pulse, 0);
    key_mode = 1'b0;
    cycles(2);
    q = cyc;
    pq.push_back(q + 4);
    pq.push_back(q + 8);
    rst_n = 1'b1;
    push_state("after_reset", 0, 0, 2, 0);
    cycles(10);
    check_state();
    cmp("pulses_consumed_c", pq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end
endmodule
